// File: rtl/mflushpwr_ctrl_if.sv
// Signal bundle between the mflushpwr controller and its CSR, L2-flush and difftest neighbours.
// The slave modport is the controller's view; master is the environment's view.
interface mflushpwr_if #(
    parameter int TIMEOUT_W = 16,
    parameter int COREID_W  = 8
);
    logic [COREID_W-1:0]  io_coreid;
    logic                 io_csr_wen;
    logic                 io_csr_wdata_flush;
    logic                 io_csr_wdata_pwr;
    logic                 io_csr_busy;
    logic                 io_status_l2FlushDone;
    logic                 io_l2_flush_req;
    logic                 io_l2_flush_ack;
    logic                 io_l2_flush_done;
    logic [TIMEOUT_W-1:0] io_timeout_cycles;
    logic                 io_pwr_down_req;
    logic                 io_evt_valid;
    logic                 io_evt_l2FlushDone;
    logic [COREID_W-1:0]  io_evt_coreid;

    modport slave (
        input  io_coreid, io_csr_wen, io_csr_wdata_flush, io_csr_wdata_pwr,
        input  io_l2_flush_ack, io_l2_flush_done, io_timeout_cycles,
        output io_csr_busy, io_status_l2FlushDone, io_l2_flush_req,
        output io_pwr_down_req, io_evt_valid, io_evt_l2FlushDone, io_evt_coreid
    );

    modport master (
        output io_coreid, io_csr_wen, io_csr_wdata_flush, io_csr_wdata_pwr,
        output io_l2_flush_ack, io_l2_flush_done, io_timeout_cycles,
        input  io_csr_busy, io_status_l2FlushDone, io_l2_flush_req,
        input  io_pwr_down_req, io_evt_valid, io_evt_l2FlushDone, io_evt_coreid
    );
endinterface

// File: rtl/mflushpwr_ctrl.sv
// mflushpwr controller: CSR write -> L2 flush req/ack/done (with optional timeout) -> difftest
// event, optionally followed by a terminal power-down request.
module mflushpwr_ctrl #(
    parameter int TIMEOUT_W = 16,
    parameter int COREID_W  = 8
) (
    input  logic          clock,
    input  logic          reset,
    mflushpwr_if.slave    mfp
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_EVT  = 3'd3,
        S_PWR  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic [COREID_W-1:0]   r_coreid;
    logic                  r_pwr_latched;
    logic                  r_result;
    logic                  r_status;
    logic [TIMEOUT_W:0]    w_cnt_inc;
    logic                  w_timeout;

    // One extra bit so a saturated counter can never alias onto a programmed limit.
    assign w_cnt_inc = {1'b0, r_cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
    assign w_timeout = (mfp.io_timeout_cycles != '0) &&
                       (w_cnt_inc == {1'b0, mfp.io_timeout_cycles});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mfp.io_csr_wen && mfp.io_csr_wdata_flush)
                    w_next = S_REQ;
                else if (mfp.io_csr_wen && mfp.io_csr_wdata_pwr && r_status)
                    w_next = S_PWR;
            end
            S_REQ: begin
                if (mfp.io_l2_flush_ack)
                    w_next = mfp.io_l2_flush_done ? S_EVT : S_WAIT;
            end
            S_WAIT: begin
                if (mfp.io_l2_flush_done || w_timeout)
                    w_next = S_EVT;
            end
            S_EVT:   w_next = (r_pwr_latched && r_result) ? S_PWR : S_IDLE;
            S_PWR:   w_next = S_PWR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_coreid      <= '0;
            r_pwr_latched <= 1'b0;
            r_result      <= 1'b0;
            r_status      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mfp.io_csr_wen && mfp.io_csr_wdata_flush) begin
                        r_coreid      <= mfp.io_coreid;
                        r_pwr_latched <= mfp.io_csr_wdata_pwr;
                        r_status      <= 1'b0;
                    end else if (mfp.io_csr_wen && !mfp.io_csr_wdata_pwr) begin
                        r_status      <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mfp.io_l2_flush_ack) begin
                        r_cnt <= '0;
                        if (mfp.io_l2_flush_done) r_result <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '1) r_cnt <= w_cnt_inc[TIMEOUT_W-1:0];
                    // Done takes priority over a coincident timeout.
                    if (mfp.io_l2_flush_done) r_result <= 1'b1;
                    else if (w_timeout)       r_result <= 1'b0;
                end
                S_EVT:   r_status <= r_result;
                default: ;
            endcase
        end
    end

    assign mfp.io_csr_busy           = (r_state != S_IDLE);
    assign mfp.io_status_l2FlushDone = r_status;
    assign mfp.io_l2_flush_req       = (r_state == S_REQ);
    assign mfp.io_pwr_down_req       = (r_state == S_PWR);
    assign mfp.io_evt_valid          = (r_state == S_EVT);
    assign mfp.io_evt_l2FlushDone    = (r_state == S_EVT) && r_result;
    assign mfp.io_evt_coreid         = (r_state == S_EVT) ? r_coreid : '0;
endmodule
